// File: rtl/soc_brom_loader.sv
// Boot-time copier: moves a block of 32-bit words from the boot ROM to RAM over request/ready.
// Define SOC_BROM_LOADER_CHECKSUM_EN to build a running sum of the words read on o_checksum.
module soc_brom_loader #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_start,
  input  logic [31:0] i_src_address,
  input  logic [31:0] i_dst_address,
  input  logic [15:0] i_count,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_error,
  output logic [31:0] o_checksum,
  output logic        o_rd_request,
  output logic [31:0] o_rd_address,
  input  logic [31:0] i_rd_rdata,
  input  logic        i_rd_ready,
  output logic        o_wr_request,
  output logic [31:0] o_wr_address,
  output logic [31:0] o_wr_wdata,
  input  logic        i_wr_ready
);

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned DATA_W     = 32;
  localparam int unsigned COUNT_W    = 16;
  localparam int unsigned WAIT_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int unsigned WAIT_LIMIT = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                busy_d, done_d, error_d;
  logic                rd_req_d, wr_req_d;
  logic [ADDR_W-1:0]   rd_addr_d, wr_addr_d;
  logic [DATA_W-1:0]   wdata_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [COUNT_W-1:0]  remaining_q, remaining_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                timeout_hit_c;

`ifdef SOC_BROM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum_q, sum_d;
  assign o_checksum = sum_q;
`else
  assign o_checksum = '0;
`endif

  // A zero TIMEOUT disables the abort path entirely.
  assign timeout_hit_c = (TIMEOUT != 0) && (wait_q == WAIT_W'(WAIT_LIMIT));

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    busy_d      = o_busy;
    done_d      = 1'b0;
    error_d     = o_error;
    rd_req_d    = o_rd_request;
    rd_addr_d   = o_rd_address;
    wr_req_d    = o_wr_request;
    wr_addr_d   = o_wr_address;
    wdata_d     = o_wr_wdata;
    dst_d       = dst_q;
    remaining_d = remaining_q;
    wait_d      = wait_q;
`ifdef SOC_BROM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          error_d = 1'b0;
          if (i_count == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d      = 1'b1;
            rd_req_d    = 1'b1;
            rd_addr_d   = i_src_address;
            dst_d       = i_dst_address;
            remaining_d = i_count;
            wait_d      = '0;
`ifdef SOC_BROM_LOADER_CHECKSUM_EN
            sum_d       = '0;
`endif
            state_d     = ST_READ;
          end
        end
      end
      ST_READ: begin
        if (i_rd_ready) begin
          rd_req_d  = 1'b0;
          wdata_d   = i_rd_rdata;
          wr_req_d  = 1'b1;
          wr_addr_d = dst_q;
          wait_d    = '0;
`ifdef SOC_BROM_LOADER_CHECKSUM_EN
          sum_d     = sum_q + i_rd_rdata;
`endif
          state_d   = ST_WRITE;
        end else if (timeout_hit_c) begin
          rd_req_d = 1'b0;
          error_d  = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WRITE: begin
        if (i_wr_ready) begin
          wr_req_d    = 1'b0;
          rd_addr_d   = o_rd_address + WORD_BYTES;
          wr_addr_d   = o_wr_address + WORD_BYTES;
          dst_d       = dst_q + WORD_BYTES;
          remaining_d = remaining_q - COUNT_W'(1);
          if (remaining_q == COUNT_W'(1)) begin
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            rd_req_d = 1'b1;
            wait_d   = '0;
            state_d  = ST_READ;
          end
        end else if (timeout_hit_c) begin
          wr_req_d = 1'b0;
          error_d  = 1'b1;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = ST_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q      <= ST_IDLE;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_error      <= 1'b0;
      o_rd_request <= 1'b0;
      o_rd_address <= '0;
      o_wr_request <= 1'b0;
      o_wr_address <= '0;
      o_wr_wdata   <= '0;
      dst_q        <= '0;
      remaining_q  <= '0;
      wait_q       <= '0;
`ifdef SOC_BROM_LOADER_CHECKSUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      o_busy       <= busy_d;
      o_done       <= done_d;
      o_error      <= error_d;
      o_rd_request <= rd_req_d;
      o_rd_address <= rd_addr_d;
      o_wr_request <= wr_req_d;
      o_wr_address <= wr_addr_d;
      o_wr_wdata   <= wdata_d;
      dst_q        <= dst_d;
      remaining_q  <= remaining_d;
      wait_q       <= wait_d;
`ifdef SOC_BROM_LOADER_CHECKSUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_soc_brom_loader.sv
// Bench for soc_brom_loader: registered ROM/RAM responders, transaction logs and a word-level copy model.
module tb_soc_brom_loader;

  logic        i_clock = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_start = 1'b0;
  logic [31:0] i_src_address = '0;
  logic [31:0] i_dst_address = '0;
  logic [15:0] i_count = '0;
  logic        o_busy, o_done, o_error;
  logic [31:0] o_checksum;
  logic        o_rd_request;
  logic [31:0] o_rd_address;
  logic [31:0] i_rd_rdata;
  logic        i_rd_ready = 1'b0;
  logic        o_wr_request;
  logic [31:0] o_wr_address;
  logic [31:0] o_wr_wdata;
  logic        i_wr_ready = 1'b0;

  soc_brom_loader dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
    .i_src_address(i_src_address), .i_dst_address(i_dst_address), .i_count(i_count),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error), .o_checksum(o_checksum),
    .o_rd_request(o_rd_request), .o_rd_address(o_rd_address),
    .i_rd_rdata(i_rd_rdata), .i_rd_ready(i_rd_ready),
    .o_wr_request(o_wr_request), .o_wr_address(o_wr_address),
    .o_wr_wdata(o_wr_wdata), .i_wr_ready(i_wr_ready)
  );

  always #5 i_clock = ~i_clock;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [31:0] rom [0:63];
  logic        rd_always = 1'b0;
  logic        ram_stall = 1'b0;

  logic [31:0] rd_log[$];
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int busy_cycles = 0;
  int done_count  = 0;
  int rd_req_cycles = 0;
  int wr_req_cycles = 0;

  function automatic logic [31:0] rom_at(input logic [31:0] addr);
    return rom[addr[7:2]];
  endfunction

  // Responders: ready follows the request one cycle later; ROM data is looked up from the live address.
  assign i_rd_rdata = rom_at(o_rd_address);
  always @(posedge i_clock) begin
    cyc <= cyc + 1;
    i_rd_ready <= rd_always ? 1'b1 : o_rd_request;
    i_wr_ready <= o_wr_request && !ram_stall;
  end

  // Monitor between edges: records what the next active edge will accept.
  always @(negedge i_clock) begin
    if (!i_reset) begin
      if (o_rd_request && i_rd_ready) rd_log.push_back(o_rd_address);
      if (o_wr_request && i_wr_ready) begin
        wr_addr_log.push_back(o_wr_address);
        wr_data_log.push_back(o_wr_wdata);
      end
    end
    if (o_busy === 1'b1) busy_cycles++;
    if (o_done === 1'b1) done_count++;
    if (o_rd_request === 1'b1) rd_req_cycles++;
    if (o_wr_request === 1'b1) wr_req_cycles++;
  end

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic run_copy(input logic [31:0] src, input logic [31:0] dst, input int cnt,
                          input bit timing, input bit mid_start);
    int rd_base, wr_base, busy_base, done_base, e0, n_r, n_w;
    bit got;
    logic [31:0] sum, a, d;
    rd_base = rd_log.size(); wr_base = wr_addr_log.size();
    busy_base = busy_cycles; done_base = done_count;
    i_src_address = src; i_dst_address = dst; i_count = 16'(cnt); i_start = 1'b1;
    tick();
    e0 = cyc;
    i_start = 1'b0;
    i_src_address = $urandom; i_dst_address = $urandom; i_count = 16'($urandom);
    checks++;
    if (o_error !== 1'b0 || o_busy !== 1'b1) begin
      fails++;
      $display("FAIL copy_accept: error=%b busy=%b, want error=0 busy=1", o_error, o_busy);
    end
    if (mid_start) begin
      tick(); tick();
      i_start = 1'b1; i_src_address = 32'hDEAD_0000; i_count = 16'd7;
      tick();
      i_start = 1'b0;
    end
    got = 1'b0;
    for (int k = 0; k < 40 * cnt + 40 && !got; k++) begin
      tick();
      if (o_done === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got) begin
      fails++;
      $display("FAIL copy_done_wait: no o_done within budget (count=%0d)", cnt);
    end
    checks++;
    if (o_error !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL copy_end_flags: error=%b busy=%b, want 0 0", o_error, o_busy);
    end
    if (timing) begin
      checks++;
      if ((cyc - e0) != 4 * cnt) begin
        fails++;
        $display("FAIL copy_latency: done %0d cycles after start, want %0d", cyc - e0, 4 * cnt);
      end
      checks++;
      if ((busy_cycles - busy_base) != 4 * cnt) begin
        fails++;
        $display("FAIL copy_busy_len: busy %0d cycles, want %0d", busy_cycles - busy_base, 4 * cnt);
      end
    end
    sum = '0;
    n_r = rd_log.size() - rd_base;
    n_w = wr_addr_log.size() - wr_base;
    checks++;
    if (n_r != cnt || n_w != cnt) begin
      fails++;
      $display("FAIL copy_txn_count: reads=%0d writes=%0d, want %0d each", n_r, n_w, cnt);
    end
    for (int k = 0; k < cnt; k++) begin
      a = src + 32'(4 * k);
      d = rom_at(a);
      sum = sum + d;
      if (k < n_r && k < n_w) begin
        checks++;
        if (rd_log[rd_base + k] !== a || wr_addr_log[wr_base + k] !== dst + 32'(4 * k) ||
            wr_data_log[wr_base + k] !== d) begin
          fails++;
          $display("FAIL copy_word%0d: rd=%h wr=%h data=%h, want rd=%h wr=%h data=%h", k,
                   rd_log[rd_base + k], wr_addr_log[wr_base + k], wr_data_log[wr_base + k],
                   a, dst + 32'(4 * k), d);
        end
      end
    end
`ifndef SOC_BROM_LOADER_CHECKSUM_EN
    sum = '0;
`endif
    checks++;
    if (o_checksum !== sum) begin
      fails++;
      $display("FAIL copy_checksum: got %h, want %h", o_checksum, sum);
    end
    tick();
    checks++;
    if (o_done !== 1'b0 || (done_count - done_base) != 1) begin
      fails++;
      $display("FAIL copy_done_pulse: done=%b pulses=%0d, want 0 and 1 pulse", o_done, done_count - done_base);
    end
  endtask

  task automatic test_reset();
    int rq, wq;
    i_reset = 1'b1;
    tick(); tick();
    i_reset = 1'b0;
    rq = rd_req_cycles; wq = wr_req_cycles;
    repeat (10) tick();
    checks++;
    if ({o_busy, o_done, o_error, o_rd_request, o_wr_request} !== 5'b0) begin
      fails++;
      $display("FAIL reset_flags: busy/done/error/rd/wr=%b, want 00000",
               {o_busy, o_done, o_error, o_rd_request, o_wr_request});
    end
    checks++;
    if (o_rd_address !== '0 || o_wr_address !== '0 || o_wr_wdata !== '0 || o_checksum !== '0) begin
      fails++;
      $display("FAIL reset_data: rd=%h wr=%h wdata=%h sum=%h, want all 0",
               o_rd_address, o_wr_address, o_wr_wdata, o_checksum);
    end
    checks++;
    if (rd_req_cycles != rq || wr_req_cycles != wq) begin
      fails++;
      $display("FAIL reset_idle_requests: %0d/%0d request cycles, want 0/0", rd_req_cycles - rq, wr_req_cycles - wq);
    end
  endtask

  task automatic test_basic_copy();
    rom[0] = 32'h0000_0013;
    rom[1] = 32'h0010_0093;
    run_copy(32'h0, 32'h1000, 2, 1'b1, 1'b0);
  endtask

  task automatic test_random_copies();
    logic [31:0] s, d;
    for (int it = 0; it < 4; it++) begin
      if (it == 0) begin
        s = 32'hFFFF_FFF8; d = 32'hFFFF_FFFC;
      end else begin
        s = $urandom; s[1:0] = 2'b00;
        d = $urandom; d[1:0] = 2'b00;
      end
      run_copy(s, d, $urandom_range(1, 6), 1'b1, 1'b0);
    end
  endtask

  task automatic test_zero_count();
    int rq, wq, bq;
    rq = rd_req_cycles; wq = wr_req_cycles; bq = busy_cycles;
    i_count = 16'd0; i_src_address = 32'h40; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    checks++;
    if (o_done !== 1'b1 || o_busy !== 1'b0 || o_error !== 1'b0) begin
      fails++;
      $display("FAIL zero_count_done: done=%b busy=%b error=%b, want 1 0 0", o_done, o_busy, o_error);
    end
    tick(); tick();
    checks++;
    if (o_done !== 1'b0 || busy_cycles != bq || rd_req_cycles != rq || wr_req_cycles != wq) begin
      fails++;
      $display("FAIL zero_count_quiet: done=%b busy_cyc=%0d rd_cyc=%0d wr_cyc=%0d, want 0 0 0 0",
               o_done, busy_cycles - bq, rd_req_cycles - rq, wr_req_cycles - wq);
    end
  endtask

  task automatic test_timeout();
    int rise, fall, wb;
    bit seen;
    ram_stall = 1'b1;
    wb = wr_addr_log.size();
    i_src_address = 32'h80; i_dst_address = 32'h2000; i_count = 16'd2; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    rise = 0; fall = 0; seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      tick();
      if (o_wr_request === 1'b1) begin seen = 1'b1; rise = cyc; end
    end
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen && rise != 0; k++) begin
      tick();
      if (o_wr_request === 1'b0) begin seen = 1'b1; fall = cyc; end
    end
    checks++;
    if (!seen || (fall - rise) != 255) begin
      fails++;
      $display("FAIL timeout_len: write request held %0d cycles (seen=%0d), want 255", fall - rise, seen);
    end
    checks++;
    if (o_error !== 1'b1 || o_done !== 1'b1 || o_busy !== 1'b0 || o_rd_request !== 1'b0) begin
      fails++;
      $display("FAIL timeout_flags: error=%b done=%b busy=%b rd=%b, want 1 1 0 0",
               o_error, o_done, o_busy, o_rd_request);
    end
    ram_stall = 1'b0;
    repeat (3) tick();
    checks++;
    if (o_error !== 1'b1 || wr_addr_log.size() != wb) begin
      fails++;
      $display("FAIL timeout_sticky: error=%b writes=%0d, want 1 and 0", o_error, wr_addr_log.size() - wb);
    end
  endtask

  task automatic test_reset_mid_copy();
    int wb, db, rb;
    bit seen;
    wb = wr_addr_log.size();
    i_src_address = 32'h10; i_dst_address = 32'h3000; i_count = 16'd4; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      tick();
      if (o_wr_request === 1'b1 && wr_addr_log.size() == wb + 1) seen = 1'b1;
    end
    db = done_count; rb = rd_log.size();
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    checks++;
    if (!seen || o_rd_request !== 1'b0 || o_wr_request !== 1'b0 || o_busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_copy: reached=%0d rd=%b wr=%b busy=%b, want 1 0 0 0",
               seen, o_rd_request, o_wr_request, o_busy);
    end
    repeat (6) tick();
    checks++;
    if (done_count != db || wr_addr_log.size() != wb + 1 || rd_log.size() != rb) begin
      fails++;
      $display("FAIL reset_mid_quiet: done=%0d writes=%0d reads=%0d, want 0 1 0",
               done_count - db, wr_addr_log.size() - wb, rd_log.size() - rb);
    end
    run_copy(32'h20, 32'h3100, 3, 1'b1, 1'b0);
  endtask

  task automatic test_back_to_back();
    int rb, db, bq;
    rd_always = 1'b1;
    run_copy(32'h100, 32'h4000, 5, 1'b0, 1'b1);
    rb = rd_log.size(); db = done_count; bq = busy_cycles;
    repeat (10) tick();
    checks++;
    if (rd_log.size() != rb || done_count != db || busy_cycles != bq) begin
      fails++;
      $display("FAIL restart_ignored: reads=%0d dones=%0d busy_cyc=%0d after copy, want 0 0 0",
               rd_log.size() - rb, done_count - db, busy_cycles - bq);
    end
    rd_always = 1'b0;
    tick();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = $urandom;
    tick();
    test_reset();
    test_basic_copy();
    test_random_copies();
    test_timeout();
    test_zero_count();
    test_reset_mid_copy();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
